// File: rtl/alu_pipe.sv
// Registered, valid/ready ALU with an iterative shift-add multiplier.
// Non-MUL ops complete in one cycle; MUL holds the block busy for WIDTH cycles.
module alu_pipe #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             carry_out,
   output logic             overflow,
   output logic             negative,
   output logic             illegal_op
);

   localparam int S  = $clog2(WIDTH);
   localparam int CW = S + 1;

   typedef enum logic {IDLE, MUL_BUSY} stateT;
   stateT stateReg, stateNext;

   logic [2*WIDTH-1:0] mulAReg, accReg, accNext;
   logic [WIDTH-1:0]   mulBReg;
   logic [CW-1:0]      countReg;

   logic             accept, isMul, mulDone, loadOut;
   logic [WIDTH:0]   sumWide, diffWide;
   logic [S-1:0]     shamt;
   logic [WIDTH-1:0] aluRes, outResNext;
   logic             aluCarry, aluOvf, aluIllegal;
   logic             outCarryNext, outOvfNext, outIllegalNext;

   assign in_ready = (stateReg == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign isMul    = MUL_EN && (alu_op == 4'b1011);
   assign shamt    = operand_b[S-1:0];
   assign sumWide  = {1'b0, operand_a} + {1'b0, operand_b};
   assign diffWide = {1'b0, operand_a} - {1'b0, operand_b};
   assign accNext  = accReg + (mulBReg[0] ? mulAReg : '0);
   // The last shift-add step and the output load share one edge.
   assign mulDone  = (stateReg == MUL_BUSY) && (countReg == CW'(1));
   assign loadOut  = mulDone || (accept && !isMul);

   always_comb begin
      aluRes     = '0;
      aluCarry   = 1'b0;
      aluOvf     = 1'b0;
      aluIllegal = 1'b0;
      case (alu_op)
         4'b0000: begin
            aluRes   = sumWide[WIDTH-1:0];
            aluCarry = sumWide[WIDTH];
            aluOvf   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                       (sumWide[WIDTH-1] != operand_a[WIDTH-1]);
         end
         4'b0001: begin
            aluRes   = diffWide[WIDTH-1:0];
            aluCarry = diffWide[WIDTH];
            aluOvf   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                       (diffWide[WIDTH-1] != operand_a[WIDTH-1]);
         end
         4'b0010: aluRes = operand_a & operand_b;
         4'b0011: aluRes = operand_a | operand_b;
         4'b0100: aluRes = operand_a ^ operand_b;
         4'b0101: aluRes = ~operand_a;
         4'b0110: aluRes = operand_a << shamt;
         4'b0111: aluRes = $signed(operand_a) >>> shamt;
         4'b1000: aluRes = operand_a >> shamt;
         4'b1001: aluRes = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
         4'b1010: aluRes = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
         default: aluIllegal = 1'b1;
      endcase
   end

   always_comb begin
      outResNext     = aluRes;
      outCarryNext   = aluCarry;
      outOvfNext     = aluOvf;
      outIllegalNext = aluIllegal;
      if (mulDone) begin
         outResNext     = accNext[WIDTH-1:0];
         outCarryNext   = 1'b0;
         outOvfNext     = |accNext[2*WIDTH-1:WIDTH];
         outIllegalNext = 1'b0;
      end
   end

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:     if (accept && isMul) stateNext = MUL_BUSY;
         MUL_BUSY: if (mulDone)         stateNext = IDLE;
         default:  stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateReg <= IDLE;
         countReg <= '0;
         mulAReg  <= '0;
         mulBReg  <= '0;
         accReg   <= '0;
      end else begin
         stateReg <= stateNext;
         if (accept && isMul) begin
            mulAReg  <= {{WIDTH{1'b0}}, operand_a};
            mulBReg  <= operand_b;
            accReg   <= '0;
            countReg <= CW'(WIDTH);
         end else if (stateReg == MUL_BUSY) begin
            accReg   <= accNext;
            mulAReg  <= mulAReg << 1;
            mulBReg  <= mulBReg >> 1;
            countReg <= countReg - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         result     <= '0;
         zero_flag  <= 1'b0;
         carry_out  <= 1'b0;
         overflow   <= 1'b0;
         negative   <= 1'b0;
         illegal_op <= 1'b0;
      end else if (loadOut) begin
         out_valid  <= 1'b1;
         result     <= outResNext;
         zero_flag  <= (outResNext == '0);
         carry_out  <= outCarryNext;
         overflow   <= outOvfNext;
         negative   <= outResNext[WIDTH-1];
         illegal_op <= outIllegalNext;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32): directed literal cases plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] operand_a, operand_b, result;
   logic [3:0]  alu_op;
   logic        zero_flag, carry_out, overflow, negative, illegal_op;

   alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero_flag(zero_flag), .carry_out(carry_out), .overflow(overflow),
      .negative(negative), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic z, c, v, n, il;
   } outT;

   int checks   = 0;
   int failures = 0;
   bit checkEn  = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   function automatic outT mk(logic [31:0] r, logic z, logic c, logic v, logic n, logic il);
      outT o;
      o.res = r; o.z = z; o.c = c; o.v = v; o.n = n; o.il = il;
      return o;
   endfunction

   // Reference: plain wide/signed arithmetic on the operands.
   function automatic outT model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      outT         o;
      longint      sa, sb, wide;
      logic [63:0] ua, ub, p;
      int          sh;
      o  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      sh = b % 32;
      case (op)
         4'd0: begin
            o.res = a + b;
            o.c   = (ua + ub) > 64'hFFFF_FFFF;
            wide  = sa + sb;
            o.v   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd1: begin
            o.res = a - b;
            o.c   = a < b;
            wide  = sa - sb;
            o.v   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd2:  o.res = a & b;
         4'd3:  o.res = a | b;
         4'd4:  o.res = a ^ b;
         4'd5:  o.res = ~a;
         4'd6:  o.res = a << sh;
         4'd7:  o.res = $signed(a) >>> sh;
         4'd8:  o.res = a >> sh;
         4'd9:  o.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd10: o.res = (a < b) ? 32'd1 : 32'd0;
         4'd11: begin
            p     = ua * ub;
            o.res = p[31:0];
            o.v   = p[63:32] != 0;
         end
         default: o.il = 1'b1;
      endcase
      o.z = (o.res == 0);
      o.n = o.res[31];
      return o;
   endfunction

   // Cycle-level expectation: is a result held, and how long until a MUL finishes.
   bit   mValid = 1'b0;
   int   mBusy  = 0;
   outT  mOut   = '0;
   outT  mMul   = '0;
   logic expReady;

   always @(negedge clk) begin
      if (checkEn) begin
         expReady = (mBusy == 0) && (!mValid || out_ready);
         chk("cmp_in_ready", in_ready, expReady);
         chk("cmp_out_valid", out_valid, mValid);
         if (mValid) begin
            chk("cmp_result", result, mOut.res);
            chk("cmp_zero", zero_flag, mOut.z);
            chk("cmp_carry", carry_out, mOut.c);
            chk("cmp_overflow", overflow, mOut.v);
            chk("cmp_negative", negative, mOut.n);
            chk("cmp_illegal", illegal_op, mOut.il);
            if (out_ready)
               $display("xfer result=0x%08h z=%0b c=%0b v=%0b n=%0b il=%0b",
                        result, zero_flag, carry_out, overflow, negative, illegal_op);
         end
         if (!rst_n) begin
            mValid = 1'b0;
            mBusy  = 0;
         end else begin
            if (mValid && out_ready) mValid = 1'b0;
            if (mBusy > 0) begin
               mBusy--;
               if (mBusy == 0) begin
                  mOut   = mMul;
                  mValid = 1'b1;
               end
            end else if (in_valid && expReady) begin
               if (alu_op == 4'd11) begin
                  mBusy = 32;
                  mMul  = model(alu_op, operand_a, operand_b);
               end else begin
                  mOut   = model(alu_op, operand_a, operand_b);
                  mValid = 1'b1;
               end
            end
         end
      end
   end

   task automatic runOp(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input outT exp, input int expLat);
      bit acc, seen;
      int lat;
      acc = 1'b0; seen = 1'b0; lat = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; alu_op = op; operand_a = a; operand_b = b;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (!acc) begin
         chk({nm, "_accept_timeout"}, 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      for (int k = 1; k <= 60 && !seen; k++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            lat  = k;
         end else begin
            chk({nm, "_busy_in_ready"}, in_ready, 0);
         end
      end
      if (!seen) begin
         chk({nm, "_result_timeout"}, 0, 1);
         return;
      end
      $display("op %s result=0x%08h latency=%0d", nm, result, lat);
      chk({nm, "_latency"}, lat, expLat);
      chk({nm, "_result"}, result, exp.res);
      chk({nm, "_zero"}, zero_flag, exp.z);
      chk({nm, "_carry"}, carry_out, exp.c);
      chk({nm, "_overflow"}, overflow, exp.v);
      chk({nm, "_negative"}, negative, exp.n);
      chk({nm, "_illegal"}, illegal_op, exp.il);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] corners [5];
      corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      case ($urandom % 4)
         0:       return corners[$urandom % 5];
         1:       return 32'($urandom % 64);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit sawStale;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      operand_a = '0; operand_b = '0; alu_op = '0;
      repeat (2) @(posedge clk);
      #1 checkEn = 1'b1;
      @(posedge clk); #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", result, 0);
      chk("reset_zero", zero_flag, 0);
      chk("reset_illegal", illegal_op, 0);
      chk("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;

      runOp("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 1, 0, 0, 0), 1);
      runOp("sub_ovf", 4'd1, 32'h8000_0000, 32'h1, mk(32'h7FFF_FFFF, 0, 0, 1, 0, 0), 1);
      runOp("sub_borrow", 4'd1, 32'h0, 32'h1, mk(32'hFFFF_FFFF, 0, 1, 0, 1, 0), 1);
      runOp("slt", 4'd9, 32'hFFFF_FFFF, 32'h1, mk(32'h1, 0, 0, 0, 0, 0), 1);
      runOp("sltu", 4'd10, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 0, 0, 0, 0), 1);
      runOp("sra36", 4'd7, 32'h8000_0000, 32'd36, mk(32'hF800_0000, 0, 0, 0, 1, 0), 1);
      runOp("srl4", 4'd8, 32'h8000_0000, 32'd4, mk(32'h0800_0000, 0, 0, 0, 0, 0), 1);
      runOp("sll8", 4'd6, 32'h0000_00FF, 32'd8, mk(32'h0000_FF00, 0, 0, 0, 0, 0), 1);
      runOp("mul_big", 4'd11, 32'h0001_0000, 32'h0001_0000, mk(32'h0, 1, 0, 1, 0, 0), 33);
      runOp("mul_7x6", 4'd11, 32'd7, 32'd6, mk(32'h2A, 0, 0, 0, 0, 0), 33);
      runOp("illegal", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0, 1, 0, 0, 0, 1), 1);

      // Backpressure: one result held for three cycles, then four ADDs streamed.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; alu_op = 4'd0;
      operand_a = 32'd5; operand_b = 32'd7;
      @(posedge clk); #1;
      alu_op = 4'd1; operand_a = 32'd1; operand_b = 32'd2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_result", result, 32'd12);
         chk("bp_zero", zero_flag, 0);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; alu_op = 4'd0;
         operand_a = 32'(i * 16 + 1); operand_b = 32'h100;
         @(posedge clk); #1;
         chk("stream_valid", out_valid, 1);
         chk("stream_result", result, 32'(32'h101 + i * 16));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("stream_drained", out_valid, 0);

      // Reset in the middle of a multiply.
      in_valid = 1'b1; alu_op = 4'd11; operand_a = 32'd3; operand_b = 32'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rstmul_out_valid", out_valid, 0);
      chk("rstmul_in_ready", in_ready, 1);
      rst_n = 1'b1;
      sawStale = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (out_valid) sawStale = 1'b1;
      end
      chk("rstmul_no_stale", sawStale, 0);

      // Randomized traffic, checked by the per-cycle compare process.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom % 10) < 7;
         alu_op    = 4'($urandom_range(0, 15));
         operand_a = pick();
         operand_b = pick();
         out_ready = ($urandom % 4) != 0;
         rst_n     = ($urandom % 400) != 0;
      end
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, handshaked successor to the team's combinational ALU.
- Fully parametrised in WIDTH, with a valid/ready input and output interface and a registered result and flag bundle.
- Adds variable shift amounts, signed and unsigned compares, overflow and negative flags, and an iterative multi-cycle multiply.
- Sits between the decode/issue stage and writeback; supports backpressure from writeback.

Parameters:
- WIDTH, 32, operand and result width; power of two, at least 8.
- MUL_EN, 1, when 1 the MUL opcode is implemented; when 0 it is treated as illegal.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept an operation this cycle.
- operand_a  in  WIDTH  operand A.
- operand_b  in  WIDTH  operand B; low $clog2(WIDTH) bits give the shift amount.
- alu_op  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero_flag  out  1  result == 0.
- carry_out  out  1  ADD: carry out of MSB. SUB: borrow (A < B unsigned). All other ops: 0.
- overflow  out  1  ADD/SUB: signed overflow. MUL: upper WIDTH bits of the 2*WIDTH unsigned product are nonzero. All other ops: 0.
- negative  out  1  result[WIDTH-1].
- illegal_op  out  1  the opcode was unimplemented.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n sampled low at a rising edge):
  - out_valid=0, result=0, all flags=0, illegal_op=0.
  - State goes to IDLE and the multiply counter is cleared.
  - Reset mid-multiply abandons the operation; no result is emitted.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 NOT A.
  - 0110 SLL: A << B[S-1:0].
  - 0111 SRA: arithmetic A >> B[S-1:0].
  - 1000 SRL: logical A >> B[S-1:0].
  - 1001 SLT: signed A<B gives 1, else 0.
  - 1010 SLTU: unsigned compare, same encoding as SLT.
  - 1011 MUL: low WIDTH bits of A*B, unsigned.
  - 1100–1111 (and 1011 when MUL_EN=0): illegal. Emits result=0, flags 0 except zero_flag=1, illegal_op=1, with single-cycle latency.
  - S = $clog2(WIDTH).
- Handshake:
  - Acceptance occurs when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from state, out_valid and out_ready only, never from in_valid.
  - The output register holds result, flags and out_valid stable while out_valid && !out_ready.
  - When out_valid && out_ready and no new result is loaded that edge, out_valid drops to 0.
- FSM states: IDLE, MUL_BUSY.
  - IDLE, accept non-MUL op: the output register loads at the same edge. Latency 1 cycle; out_valid is high in the cycle after acceptance.
  - Back-to-back non-MUL ops sustain one op per cycle when out_ready=1.
  - IDLE, accept MUL: capture A, B into internal registers, clear a 2*WIDTH accumulator, set counter=WIDTH, go to MUL_BUSY. The output register drains normally (out_valid falls if consumed).
  - MUL_BUSY: one shift-add step per cycle; counter decrements.
  - When the counter reaches 0, load result and flags, assert out_valid, return to IDLE.
  - Total MUL latency is WIDTH+1 cycles from acceptance to out_valid high.
  - in_ready=0 throughout MUL_BUSY.
- Width rules:
  - ADD/SUB use a WIDTH+1 internal sum.
  - Overflow is computed from operand and result sign bits.
  - Shift amounts at or above WIDTH cannot occur, because only S bits are used (B=36 with WIDTH=32 shifts by 4).
- Inputs are ignored when not accepted. An operand change while in_ready=0 has no effect.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001 -> result 0x00000000, zero_flag=1, carry_out=1, overflow=0, out_valid exactly one cycle after acceptance.
- SUB 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow=1, carry_out=0. SLT A=0xFFFFFFFF, B=0x00000001 -> 1. SLTU with the same operands -> 0.
- Shifts:
  - SRA 0x80000000 by B=36 -> 0xF8000000, negative=1.
  - SRL 0x80000000 by 4 -> 0x08000000.
  - SLL 0x000000FF by 8 -> 0x0000FF00.
- MUL 0x00010000*0x00010000 -> result 0x00000000, overflow=1, zero_flag=1, out_valid 33 cycles after acceptance, in_ready=0 for cycles 1–32.
- MUL 7*6 -> 0x0000002A, overflow=0.
- Backpressure: hold out_ready=0 for 3 cycles with a result pending -> result and flags stable, in_ready=0, no acceptance. Then stream 4 ADDs with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
- Reset and illegal op:
  - rst_n low 10 cycles into a MUL -> next edge out_valid=0, in_ready=1, and no stale result appears afterwards.
  - alu_op=1111 -> result 0, zero_flag=1, illegal_op=1.
